// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master bit-level line driver:
// command codes, FSM state and phase encodings, and the per-phase line table.
package i2c_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    STOP  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2,
    PH_D = 2'd3
  } phase_e;

  // Map a command code onto the FSM state that executes it.
  function automatic state_e cmd_state(input logic [1:0] code);
    state_e st;
    st = IDLE;
    case (code)
      CMD_START: st = START;
      CMD_STOP:  st = STOP;
      CMD_WRITE: st = WRITE;
      CMD_READ:  st = READ;
      default:   st = IDLE;
    endcase
    return st;
  endfunction

  // Line enables {scl, sda} for a command in a given phase (1 = released).
  // START phase A keeps SCL where it is so a repeated START does not glitch SCL high early.
  function automatic logic [1:0] phase_lines(input state_e st, input phase_e ph,
                                             input logic din, input logic scl_now);
    logic [1:0] lines;
    lines = 2'b11;
    case (st)
      START: begin
        case (ph)
          PH_A:    lines = {scl_now, 1'b1};
          PH_B:    lines = 2'b11;
          PH_C:    lines = 2'b10;
          PH_D:    lines = 2'b00;
          default: lines = 2'b11;
        endcase
      end
      STOP: begin
        case (ph)
          PH_A:    lines = 2'b00;
          PH_B:    lines = 2'b10;
          PH_C:    lines = 2'b11;
          PH_D:    lines = 2'b11;
          default: lines = 2'b11;
        endcase
      end
      WRITE: begin
        case (ph)
          PH_A:    lines = {1'b0, din};
          PH_B:    lines = {1'b1, din};
          PH_C:    lines = {1'b1, din};
          PH_D:    lines = {1'b0, din};
          default: lines = 2'b11;
        endcase
      end
      READ: begin
        case (ph)
          PH_A:    lines = 2'b01;
          PH_B:    lines = 2'b11;
          PH_C:    lines = 2'b11;
          PH_D:    lines = 2'b01;
          default: lines = 2'b11;
        endcase
      end
      default: lines = 2'b11;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-bit phase timer: loads a period at command accept, counts down to zero,
// emits a one-cycle tick on the last cycle of each phase and reloads itself.
// While hold is high (SCL being stretched) the count sits at the reload value.
module i2c_qtr_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;

  assign tick = en & ~hold & (cnt_r == CNT_ZERO);

  // Down-counter with load, stretch hold and automatic reload at phase end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      if (hold) begin
        cnt_r <= reload_val;
      end else if (cnt_r == CNT_ZERO) begin
        cnt_r <= reload_val;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/i2c_bit_gen.sv
// I2C master bit-level line driver. Runs one START/STOP/WRITE/READ command per
// handshake through four timed phases, drives the open-drain SCL/SDA enables,
// honours clock stretching, samples READ data and detects lost arbitration.
module i2c_bit_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             cmd_din,
  output logic             done,
  output logic             dout,
  output logic             al,
  output logic             own,
  input  logic             bus_busy,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o
);

  state_e           state_r, state_nxt_s;
  phase_e           phase_r, phase_nxt_s;
  logic [DIV_W-1:0] div_r, div_nxt_s;
  logic             din_r, din_nxt_s;
  logic             scl_r, scl_nxt_s;
  logic             sda_r, sda_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             done_r, done_nxt_s;
  logic             al_r, al_nxt_s;
  logic             own_r, own_nxt_s;
  logic             dout_r, dout_nxt_s;
  logic             lost_s;
  logic             tick_s;
  logic             accept_s;
  logic             active_s;
  logic             hold_s;

  assign accept_s = cmd_valid & ready_r;
  assign active_s = (state_r != IDLE);
  // A slave holds SCL low while we release it in phase B: freeze the phase.
  assign hold_s   = active_s & (phase_r == PH_B) & scl_r & ~scl_i;

  i2c_qtr_timer #(.DIV_W(DIV_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s),
    .load_val   (clk_div),
    .en         (active_s),
    .hold       (hold_s),
    .reload_val (div_r),
    .tick       (tick_s)
  );

  // Next-state, next-line-level and handshake/status decode.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    div_nxt_s   = div_r;
    din_nxt_s   = din_r;
    scl_nxt_s   = scl_r;
    sda_nxt_s   = sda_r;
    ready_nxt_s = ready_r;
    done_nxt_s  = 1'b0;
    al_nxt_s    = 1'b0;
    own_nxt_s   = own_r;
    dout_nxt_s  = dout_r;
    lost_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          div_nxt_s = clk_div;
          din_nxt_s = cmd_din;
          if ((cmd == CMD_START) && bus_busy && !own_r) begin
            // Someone else holds the bus: refuse START without touching the lines.
            al_nxt_s    = 1'b1;
            own_nxt_s   = 1'b0;
            scl_nxt_s   = 1'b1;
            sda_nxt_s   = 1'b1;
            ready_nxt_s = 1'b1;
          end else begin
            state_nxt_s = cmd_state(cmd);
            phase_nxt_s = PH_A;
            ready_nxt_s = 1'b0;
            {scl_nxt_s, sda_nxt_s} = phase_lines(cmd_state(cmd), PH_A, cmd_din, scl_r);
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      START, STOP, WRITE, READ: begin
        if (tick_s) begin
          case (phase_r)
            PH_A: begin
              phase_nxt_s = PH_B;
              {scl_nxt_s, sda_nxt_s} = phase_lines(state_r, PH_B, din_r, scl_r);
            end
            PH_B: begin
              phase_nxt_s = PH_C;
              {scl_nxt_s, sda_nxt_s} = phase_lines(state_r, PH_C, din_r, scl_r);
            end
            PH_C: begin
              // SDA was released by us but reads low: another master won.
              lost_s = ((state_r == WRITE) && din_r && !sda_i) ||
                       ((state_r == STOP) && !sda_i);
              if (lost_s) begin
                al_nxt_s    = 1'b1;
                state_nxt_s = IDLE;
                phase_nxt_s = PH_A;
                scl_nxt_s   = 1'b1;
                sda_nxt_s   = 1'b1;
                own_nxt_s   = 1'b0;
                ready_nxt_s = 1'b1;
              end else begin
                if (state_r == READ) begin
                  dout_nxt_s = sda_i;
                end else begin
                  dout_nxt_s = dout_r;
                end
                phase_nxt_s = PH_D;
                {scl_nxt_s, sda_nxt_s} = phase_lines(state_r, PH_D, din_r, scl_r);
              end
            end
            PH_D: begin
              done_nxt_s  = 1'b1;
              state_nxt_s = IDLE;
              phase_nxt_s = PH_A;
              ready_nxt_s = 1'b1;
              if (state_r == START) begin
                own_nxt_s = 1'b1;
              end else if (state_r == STOP) begin
                own_nxt_s = 1'b0;
              end else begin
                own_nxt_s = own_r;
              end
            end
            default: begin
              state_nxt_s = IDLE;
              phase_nxt_s = PH_A;
              ready_nxt_s = 1'b1;
            end
          endcase
        end else begin
          phase_nxt_s = phase_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        phase_nxt_s = PH_A;
        scl_nxt_s   = 1'b1;
        sda_nxt_s   = 1'b1;
        ready_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM state and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      phase_r <= PH_A;
    end else begin
      state_r <= state_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Latched command operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r   <= {DIV_W{1'b0}};
      din_r   <= 1'b0;
      scl_r   <= 1'b1;
      sda_r   <= 1'b1;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      al_r    <= 1'b0;
      own_r   <= 1'b0;
      dout_r  <= 1'b0;
    end else begin
      div_r   <= div_nxt_s;
      din_r   <= din_nxt_s;
      scl_r   <= scl_nxt_s;
      sda_r   <= sda_nxt_s;
      ready_r <= ready_nxt_s;
      done_r  <= done_nxt_s;
      al_r    <= al_nxt_s;
      own_r   <= own_nxt_s;
      dout_r  <= dout_nxt_s;
    end
  end

  assign cmd_ready = ready_r;
  assign done      = done_r;
  assign al        = al_r;
  assign own       = own_r;
  assign dout      = dout_r;
  assign scl_o     = scl_r;
  assign sda_o     = sda_r;

endmodule

// File: tb/tb_i2c_bit_gen.sv
// Self-checking bench for i2c_bit_gen: open-drain bus model with external pull-downs,
// scoreboard of expected done/al events, per-phase line level checks.
module tb_i2c_bit_gen;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clk_div;
  logic        cmd_valid, cmd_ready, cmd_din;
  logic [1:0]  cmd;
  logic        done, dout, al, own, bus_busy;
  logic        scl_i, sda_i, scl_o, sda_o;
  logic        ext_scl, ext_sda;

  assign scl_i = scl_o & ext_scl;
  assign sda_i = sda_o & ext_sda;

  i2c_bit_gen #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_din(cmd_din), .done(done), .dout(dout), .al(al), .own(own),
    .bus_busy(bus_busy), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit is_al;
    int at;
    bit chk_dout;
    bit dout;
  } ev_t;
  ev_t sb[$];
  ev_t mon_e;

  bit exp_own;
  bit exp_scl;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference line table {scl, sda}; ph 0..3 = A..D.
  function automatic logic [1:0] exp_lines(input logic [1:0] c, input int ph,
                                           input logic d, input logic prev_scl);
    case (c)
      2'b00: case (ph) 0: return {prev_scl, 1'b1}; 1: return 2'b11; 2: return 2'b10; default: return 2'b00; endcase
      2'b01: case (ph) 0: return 2'b00; 1: return 2'b10; 2: return 2'b11; default: return 2'b11; endcase
      2'b10: case (ph) 0: return {1'b0, d}; 1: return {1'b1, d}; 2: return {1'b1, d}; default: return {1'b0, d}; endcase
      default: case (ph) 0: return 2'b01; 1: return 2'b11; 2: return 2'b11; default: return 2'b01; endcase
    endcase
  endfunction

  // Event monitor: every done/al must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (done || al)) begin
      check_val("done_al_excl", {31'd0, done & al}, 32'd0);
      check_val("event_expected", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_val("event_is_al", {31'd0, al}, {31'd0, mon_e.is_al});
        check_val("event_cycle", cyc, mon_e.at);
        if (mon_e.chk_dout) check_val("read_dout", {31'd0, dout}, {31'd0, mon_e.dout});
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one command and follow it cycle by cycle. stretch: cycles SCL held low at
  // start of phase B; sda_low: external SDA low throughout phase C; new_div >= 0:
  // clk_div input changed at start of phase B.
  task automatic do_cmd(input logic [1:0] c, input logic d, input int div,
                        input int stretch, input bit sda_low, input int new_div);
    int t, n, ev, b0, c0, d0, hi;
    bit is_al, start_al;
    ev_t e;
    wait_ready();
    n = div + 1;
    start_al = (c == CMD_START) && bus_busy && !exp_own;
    is_al = start_al || ((c == CMD_WRITE) && d && sda_low) || ((c == CMD_STOP) && sda_low);
    t  = cyc;
    b0 = t + 1 + n;
    c0 = t + 1 + 2 * n + stretch;
    d0 = t + 1 + 3 * n + stretch;
    ev = start_al ? t + 1 : (is_al ? d0 : d0 + n);
    e.is_al = is_al; e.at = ev; e.chk_dout = (c == CMD_READ) && !is_al; e.dout = !sda_low;
    sb.push_back(e);
    cmd = c; cmd_din = d; clk_div = div[15:0]; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = c ^ 2'b11;
    cmd_din = ~d;
    hi = 0;
    for (int k = t + 1; k < ev; k++) begin
      if (k == b0 && new_div >= 0) clk_div = new_div[15:0];
      if (k == b0 && stretch > 0) ext_scl = 1'b0;
      if (k == b0 + stretch) ext_scl = 1'b1;
      if (k == c0 && sda_low) ext_sda = 1'b0;
      if (k == d0) ext_sda = 1'b1;
      if (scl_o & ext_scl) hi++;
      if (k == t + 1) check_val("lines_A", {30'd0, scl_o, sda_o}, {30'd0, exp_lines(c, 0, d, exp_scl)});
      if (k == b0)    check_val("lines_B", {30'd0, scl_o, sda_o}, {30'd0, exp_lines(c, 1, d, exp_scl)});
      if (k == c0)    check_val("lines_C", {30'd0, scl_o, sda_o}, {30'd0, exp_lines(c, 2, d, exp_scl)});
      if (k == d0)    check_val("lines_D", {30'd0, scl_o, sda_o}, {30'd0, exp_lines(c, 3, d, exp_scl)});
      @(negedge clk);
    end
    ext_sda = 1'b1;
    ext_scl = 1'b1;
    if (is_al) begin
      exp_own = 1'b0;
      exp_scl = 1'b1;
    end else begin
      check_val("lines_done", {30'd0, scl_o, sda_o}, {30'd0, exp_lines(c, 3, d, exp_scl)});
      if (c == CMD_START) begin exp_own = 1'b1; exp_scl = 1'b0; end
      else if (c == CMD_STOP) begin exp_own = 1'b0; exp_scl = 1'b1; end
      else exp_scl = 1'b0;
      check_val("ready_at_done", {31'd0, cmd_ready}, 32'd1);
      check_val("own_at_done", {31'd0, own}, {31'd0, exp_own});
      if (c == CMD_WRITE || c == CMD_READ) check_val("scl_high_cycles", hi, 2 * n);
    end
    @(negedge clk);
    if (is_al) begin
      check_val("al_scl_rel", {31'd0, scl_o}, 32'd1);
      check_val("al_sda_rel", {31'd0, sda_o}, 32'd1);
      check_val("al_own", {31'd0, own}, 32'd0);
      check_val("al_ready", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_din = 1'b0; clk_div = 16'd3;
    bus_busy = 1'b0; ext_scl = 1'b1; ext_sda = 1'b1; exp_own = 1'b0; exp_scl = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_scl", {31'd0, scl_o}, 32'd1);
    check_val("rst_sda", {31'd0, sda_o}, 32'd1);
    check_val("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_dout", {31'd0, dout}, 32'd0);
    check_val("rst_al", {31'd0, al}, 32'd0);
    check_val("rst_own", {31'd0, own}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // START then STOP on an idle bus
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    do_cmd(CMD_STOP,  1'b0, 3, 0, 1'b0, -1);

    // WRITE 1, WRITE 0, READ 0, READ 1, repeated START while busy but owned
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    do_cmd(CMD_WRITE, 1'b1, 3, 0, 1'b0, -1);
    do_cmd(CMD_WRITE, 1'b0, 3, 0, 1'b0, -1);
    do_cmd(CMD_READ,  1'b0, 3, 0, 1'b1, -1);
    do_cmd(CMD_READ,  1'b0, 3, 0, 1'b0, -1);
    bus_busy = 1'b1;
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    bus_busy = 1'b0;

    // Clock stretching in phase B
    do_cmd(CMD_WRITE, 1'b1, 1, 0,  1'b0, -1);
    do_cmd(CMD_WRITE, 1'b1, 1, 10, 1'b0, -1);

    // Arbitration: WRITE 1 overridden, START on a foreign busy bus, STOP overridden
    do_cmd(CMD_WRITE, 1'b1, 3, 0, 1'b1, -1);
    bus_busy = 1'b1;
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    bus_busy = 1'b0;
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    do_cmd(CMD_STOP,  1'b0, 3, 0, 1'b1, -1);

    // Asynchronous reset in READ phase C
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    wait_ready();
    t = cyc;
    cmd = CMD_READ; cmd_din = 1'b1; clk_div = 16'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < t + 10) @(negedge clk);
    check_val("pre_rst_ready", {31'd0, cmd_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_scl", {31'd0, scl_o}, 32'd1);
    check_val("arst_sda", {31'd0, sda_o}, 32'd1);
    check_val("arst_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("arst_own", {31'd0, own}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_own = 1'b0;
    exp_scl = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_rst_idle", {31'd0, cmd_ready}, 32'd1);
    do_cmd(CMD_START, 1'b0, 0, 0, 1'b0, -1);
    do_cmd(CMD_STOP,  1'b0, 0, 0, 1'b0, -1);

    // clk_div changed mid-command
    do_cmd(CMD_START, 1'b0, 3, 0, 1'b0, -1);
    do_cmd(CMD_WRITE, 1'b1, 3, 0, 1'b0, 7);
    do_cmd(CMD_READ,  1'b0, 7, 0, 1'b0, -1);
    do_cmd(CMD_STOP,  1'b0, 7, 0, 1'b0, -1);

    repeat (5) @(negedge clk);
    check_val("sb_empty", sb.size(), 32'd0);
    check_val("end_scl", {31'd0, scl_o}, 32'd1);
    check_val("end_sda", {31'd0, sda_o}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
